// File: rtl/mux_scan_sequencer_pkg.sv
// ============================================================================
// Module   : mux_scan_sequencer_pkg
// Purpose  : State and channel encodings shared by the mux scan sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_scan_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] CH_A = 2'b00;
   localparam logic [1:0] CH_B = 2'b01;
   localparam logic [1:0] CH_C = 2'b10;
   localparam logic [1:0] CH_D = 2'b11;

   function automatic logic is_last_channel(input logic [1:0] ch);
      return (ch == CH_D);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// ============================================================================
// Module   : dwell_counter
// Purpose  : Counts cycles spent on one select code; tick marks the last one.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dwell_counter
   import mux_scan_sequencer_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_last;

   // With DWELL=1 the compare value is 0, so tick fires on every enabled cycle
   assign w_at_last = (r_cnt == c_last);
   assign tick      = en && w_at_last;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         if (w_at_last) r_cnt <= '0;
         else           r_cnt <= r_cnt + c_one;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// Module   : mux_scan_sequencer
// Purpose  : Steps a 4:1 mux through A..D, samples Z after each dwell window
//            and publishes a 4-bit snapshot with a one-cycle Done pulse.
//            MUX_SCAN_CONTINUOUS_EN: DONE re-enters SCAN directly if Start=1.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_scan_sequencer
   import mux_scan_sequencer_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Start,
   input  logic       Z,
   output logic       Sel1,
   output logic       Sel2,
   output logic       Busy,
   output logic       Done,
   output logic [3:0] Result
);

   state_t     r_state,   w_state_nxt;
   logic [1:0] r_channel, w_channel_nxt;
   logic [3:0] r_shadow,  w_shadow_nxt;
   logic [3:0] r_result,  w_result_nxt;
   logic       r_busy,    w_busy_nxt;
   logic       r_done,    w_done_nxt;
   logic       w_cnt_clr;
   logic       w_cnt_en;
   logic       w_tick;

   dwell_counter #(
      .DWELL (DWELL)
   ) u_dwell (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .clr     (w_cnt_clr),
      .en      (w_cnt_en),
      .tick    (w_tick)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= ST_IDLE;
         r_channel <= CH_A;
         r_shadow  <= '0;
         r_result  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_channel <= w_channel_nxt;
         r_shadow  <= w_shadow_nxt;
         r_result  <= w_result_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_channel_nxt = r_channel;
      w_shadow_nxt  = r_shadow;
      w_result_nxt  = r_result;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_cnt_clr     = 1'b0;
      w_cnt_en      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_state_nxt   = ST_SCAN;
               w_channel_nxt = CH_A;
               w_busy_nxt    = 1'b1;
               w_cnt_clr     = 1'b1;
            end
         end
         ST_SCAN: begin
            w_cnt_en = 1'b1;
            if (w_tick) begin
               w_shadow_nxt[r_channel] = Z;
               if (is_last_channel(r_channel)) begin
                  // Result takes the channel-D sample captured on this same edge
                  w_state_nxt   = ST_DONE;
                  w_channel_nxt = CH_A;
                  w_busy_nxt    = 1'b0;
                  w_done_nxt    = 1'b1;
                  w_result_nxt  = w_shadow_nxt;
               end else begin
                  w_channel_nxt = r_channel + 2'd1;
               end
            end
         end
         ST_DONE: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
            if (Start) begin
               w_state_nxt   = ST_SCAN;
               w_channel_nxt = CH_A;
               w_busy_nxt    = 1'b1;
               w_cnt_clr     = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
`else
            w_state_nxt = ST_IDLE;
`endif
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign Sel1   = r_channel[1];
   assign Sel2   = r_channel[0];
   assign Busy   = r_busy;
   assign Done   = r_done;
   assign Result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// ============================================================================
// Module   : tb_mux_scan_sequencer
// Purpose  : Random and directed scans of DWELL=4 and DWELL=1 sequencers
//            against a cycle-count reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_sequencer;

   localparam bit CONTINUOUS =
`ifdef MUX_SCAN_CONTINUOUS_EN
      1'b1;
`else
      1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       chk_en;
   logic [1:0] start;
   logic [3:0] pat [2];
   logic [1:0] z, sel1, sel2, busy, done;
   logic [3:0] result [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 Clk = ~Clk;

   // Behavioural 4:1 mux driven by each sequencer's selects
   assign z[0] = pat[0][{sel1[0], sel2[0]}];
   assign z[1] = pat[1][{sel1[1], sel2[1]}];

   mux_scan_sequencer #(.DWELL(4)) u_dut4 (
      .Clk (Clk), .Reset_n (Reset_n), .Start (start[0]), .Z (z[0]),
      .Sel1 (sel1[0]), .Sel2 (sel2[0]), .Busy (busy[0]), .Done (done[0]),
      .Result (result[0])
   );

   mux_scan_sequencer #(.DWELL(1)) u_dut1 (
      .Clk (Clk), .Reset_n (Reset_n), .Start (start[1]), .Z (z[1]),
      .Sel1 (sel1[1]), .Sel2 (sel2[1]), .Busy (busy[1]), .Done (done[1]),
      .Result (result[1])
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int dw(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   // Reference: a scan is "t edges since the start edge"; select is t/DWELL,
   // Z of channel k is taken when t reaches (k+1)*DWELL, done at t = 4*DWELL.
   logic [1:0] m_active, m_done;
   int         m_t [2];
   logic [3:0] m_result [2], m_snap [2];

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_active <= '0;
         m_done   <= '0;
         for (int i = 0; i < 2; i++) begin
            m_t[i]      <= 0;
            m_result[i] <= '0;
            m_snap[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            automatic int         d  = dw(i);
            automatic int         t  = m_t[i] + 1;
            automatic logic [3:0] ns = m_snap[i];
            m_done[i] <= 1'b0;
            if (m_active[i]) begin
               if (t % d == 0) ns[t/d-1] = pat[i][t/d-1];
               m_t[i]    <= t;
               m_snap[i] <= ns;
               if (t == 4 * d) begin
                  m_active[i] <= 1'b0;
                  m_done[i]   <= 1'b1;
                  m_result[i] <= ns;
               end
            end else if (start[i] && (!m_done[i] || CONTINUOUS)) begin
               m_active[i] <= 1'b1;
               m_t[i]      <= 0;
            end
         end
      end
   end

   always @(negedge Clk) begin
      if (chk_en && Reset_n) begin
         for (int i = 0; i < 2; i++) begin
            automatic int exp_sel = m_active[i] ? (m_t[i] / dw(i)) : 0;
            check_eq($sformatf("d%0d.sel", dw(i)), int'({sel1[i], sel2[i]}), exp_sel);
            check_eq($sformatf("d%0d.busy", dw(i)), int'(busy[i]), int'(m_active[i]));
            check_eq($sformatf("d%0d.done", dw(i)), int'(done[i]), int'(m_done[i]));
            check_eq($sformatf("d%0d.result", dw(i)), int'(result[i]), int'(m_result[i]));
         end
      end
   end

   task automatic pulse(input int i);
      @(negedge Clk);
      start[i] = 1'b1;
      @(negedge Clk);
      start[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int limit, output int busy_cyc);
      busy_cyc = 0;
      for (int c = 0; c < limit; c++) begin
         if (done[i]) return;
         if (busy[i]) busy_cyc++;
         @(negedge Clk);
      end
      check_eq("done_timeout", 0, 1);
   endtask

   task automatic check_all_zero(input string tag, input int i);
      check_eq({tag, ".sel"}, int'({sel1[i], sel2[i]}), 0);
      check_eq({tag, ".busy"}, int'(busy[i]), 0);
      check_eq({tag, ".done"}, int'(done[i]), 0);
      check_eq({tag, ".result"}, int'(result[i]), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nb, ndone, c;
      int td [3];

      Reset_n = 1'b0;
      chk_en  = 1'b0;
      start   = '0;
      pat[0]  = '0;
      pat[1]  = '0;
      #2;
      check_all_zero("por4", 0);
      check_all_zero("por1", 1);
      @(negedge Clk);
      Reset_n = 1'b1;
      chk_en  = 1'b1;

      // Basic scan: A=0 B=1 C=0 D=1
      pat[0] = 4'b1010;
      pulse(0);
      wait_done(0, 100, nb);
      check_eq("basic_busy_cycles", nb, 16);
      check_eq("basic_result", int'(result[0]), 10);

      // Second Start at edge 6 of a scan must be ignored
      repeat (3) @(negedge Clk);
      pat[0] = 4'($urandom);
      pulse(0);
      repeat (5) @(negedge Clk);
      start[0] = 1'b1;
      @(negedge Clk);
      start[0] = 1'b0;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clk);
         if (done[0]) ndone++;
      end
      check_eq("ignored_start_dones", ndone, 1);
      check_eq("ignored_start_busy", int'(busy[0]), 0);
      check_eq("ignored_start_result", int'(result[0]), int'(pat[0]));

      // DWELL=1, all channels high
      pat[1] = 4'b1111;
      pulse(1);
      wait_done(1, 20, nb);
      check_eq("dwell1_busy_cycles", nb, 4);
      check_eq("dwell1_result", int'(result[1]), 15);

      // Reset at edge 9 of a scan following a 1010 result
      repeat (3) @(negedge Clk);
      pat[0] = 4'b1010;
      pulse(0);
      wait_done(0, 100, nb);
      check_eq("prior_result", int'(result[0]), 10);
      repeat (3) @(negedge Clk);
      pulse(0);
      repeat (8) @(negedge Clk);
      @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      check_all_zero("midrst", 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge Clk);
         if (done[0]) ndone++;
      end
      check_eq("midrst_no_done", ndone, 0);
      pulse(0);
      wait_done(0, 100, nb);
      check_eq("post_rst_result", int'(result[0]), 10);

      // Random patterns with random Start noise on both sequencers
      for (int k = 0; k < 8; k++) begin
         repeat (3) @(negedge Clk);
         pat[0] = 4'($urandom);
         pat[1] = 4'($urandom);
         start  = 2'b11;
         @(negedge Clk);
         start  = 2'b00;
         for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            start = 2'($urandom);
         end
         start = 2'b00;
         repeat (30) @(negedge Clk);
         check_eq("rand_result4", int'(result[0]), int'(pat[0]));
         check_eq("rand_result1", int'(result[1]), int'(pat[1]));
      end

      // Start held high: Done period
      pat[0] = 4'($urandom);
      td     = '{-1000, -1000, -1000};
      ndone  = 0;
      c      = 0;
      @(negedge Clk);
      start[0] = 1'b1;
      while (ndone < 3 && c < 120) begin
         @(negedge Clk);
         c++;
         if (done[0]) begin
            td[ndone] = c;
            ndone++;
         end
      end
      start[0] = 1'b0;
      check_eq("held_period1", td[1] - td[0], CONTINUOUS ? 17 : 18);
      check_eq("held_period2", td[2] - td[1], CONTINUOUS ? 17 : 18);
      repeat (30) @(negedge Clk);
      check_eq("held_result", int'(result[0]), int'(pat[0]));

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
